reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Register-file hazard scoreboard for an in-order pipeline.
//               Tracks up to three outstanding writes per register with one
//               2-bit pending counter for each of the 16 architectural
//               registers. It raises a decode-stage stall on RAW hazards
//               (a source is still pending) and on counter overflow (the
//               destination already has three writes in flight). A flush
//               clears every counter and forces a single DRAIN cycle.
//
// Configuration macro:
//   REG_SCOREBOARD_BYPASS_EN - when defined, a source whose only pending
//                              write is being written back this cycle is
//                              treated as ready (same-cycle bypass).
//                              Undefined by default: the stall holds until
//                              the counter is registered as zero.
//
// Ports:
//   clk           in   1   clock, all state updates on posedge
//   rst           in   1   asynchronous active-high reset
//   issue_valid   in   1   decode stage presents an instruction
//   issue_rs      in   4   first source register index
//   issue_rt      in   4   second source register index
//   issue_rd      in   4   destination register index
//   uses_rs       in   1   instruction reads issue_rs
//   uses_rt       in   1   instruction reads issue_rt
//   writes_rd     in   1   instruction writes issue_rd
//   wb_valid      in   1   write-back of wb_rd this cycle
//   wb_rd         in   4   write-back register index
//   flush         in   1   discard all in-flight writes
//   stall         out  1   hold the decode stage
//   busy_mask     out 16   bit i set when register i has a pending write
//   state         out  2   RUN=0, STALL=1, DRAIN=2
//   stall_cycles  out  8   saturating count of stalled cycles
//   err_underflow out  1   sticky write-back-without-pending flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [3:0]  issue_rs,
  input  logic [3:0]  issue_rt,
  input  logic [3:0]  issue_rd,
  input  logic        uses_rs,
  input  logic        uses_rt,
  input  logic        writes_rd,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  input  logic        flush,
  output logic        stall,
  output logic [15:0] busy_mask,
  output logic [1:0]  state,
  output logic [7:0]  stall_cycles,
  output logic        err_underflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned CNT_W    = 2;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 2'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = 2'd3;
  localparam logic [7:0]       SC_MAX   = 8'd255;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  // All pending counters, flattened so a 4-bit index can select any of them.
  logic [NUM_REGS*CNT_W-1:0] cnt_flat;

  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] rt_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wb_cnt;

  logic rs_busy;
  logic rt_busy;
  logic rd_full;
  logic hazard;
  logic accept;
  logic wb_underflow;

  logic [1:0] state_d;
  logic [1:0] state_q;
  logic [7:0] stall_cycles_d;
  logic [7:0] stall_cycles_q;
  logic       err_d;
  logic       err_q;

  // --------------------------------------------------------------------------
  // Hazard detection (combinational, from registered counters)
  // --------------------------------------------------------------------------
  always_comb begin
    rs_cnt = cnt_flat[issue_rs*CNT_W +: CNT_W];
    rt_cnt = cnt_flat[issue_rt*CNT_W +: CNT_W];
    rd_cnt = cnt_flat[issue_rd*CNT_W +: CNT_W];
    wb_cnt = cnt_flat[wb_rd*CNT_W +: CNT_W];

`ifdef REG_SCOREBOARD_BYPASS_EN
    // The last pending write of a source is landing right now, so its value
    // is available through the register-file bypass this same cycle.
    rs_busy = uses_rs && (rs_cnt != CNT_ZERO) &&
              !(wb_valid && (wb_rd == issue_rs) && (rs_cnt == CNT_ONE));
    rt_busy = uses_rt && (rt_cnt != CNT_ZERO) &&
              !(wb_valid && (wb_rd == issue_rt) && (rt_cnt == CNT_ONE));
`else
    rs_busy = uses_rs && (rs_cnt != CNT_ZERO);
    rt_busy = uses_rt && (rt_cnt != CNT_ZERO);
`endif

    // A fourth outstanding write would overflow the 2-bit counter.
    rd_full = writes_rd && (rd_cnt == CNT_MAX);
    hazard  = issue_valid && (rs_busy || rt_busy || rd_full);

    // DRAIN stalls unconditionally; reset forces the stall low so the decode
    // register is never frozen while the scoreboard is being cleared.
    stall  = !rst && (hazard || (state_q == ST_DRAIN));
    accept = issue_valid && !stall;

    // Flush discards the write-back along with everything else in flight.
    wb_underflow = wb_valid && (wb_cnt == CNT_ZERO) && !flush;
  end

  // --------------------------------------------------------------------------
  // Per-register pending counters
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign inc = accept && writes_rd && (issue_rd == 4'(i));
    assign dec = wb_valid && (wb_rd == 4'(i)) && (cnt_q != CNT_ZERO);

    // Simultaneous increment and decrement cancel out; flush wins over both.
    always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
        cnt_d = CNT_ZERO;
      end else if (inc && !dec) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= CNT_ZERO;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_flat[i*CNT_W +: CNT_W] = cnt_q;
    assign busy_mask[i]               = (cnt_q != CNT_ZERO);
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_DRAIN;
    end else begin
      case (state_q)
        ST_RUN:   state_d = stall ? ST_STALL : ST_RUN;
        ST_STALL: state_d = stall ? ST_STALL : ST_RUN;
        ST_DRAIN: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Statistics and error flag
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != SC_MAX)) begin
      stall_cycles_d = stall_cycles_q + 8'd1;
    end
    err_d = err_q || wb_underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= 8'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      err_q          <= err_d;
    end
  end

  assign state         = state_q;
  assign stall_cycles  = stall_cycles_q;
  assign err_underflow = err_q;

endmodule
`default_nettype wire
